// File: rtl/qkv_ram_fetch.sv
// Read-side sequencer for the Q/K/V spike line RAMs: walks the QK or V address space,
// absorbs the 1-cycle BRAM latency and streams lines through a 2-entry output FIFO.
module qkv_ram_fetch #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int ROWS   = 64,
    parameter int BLOCKS = 12
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              i_SpikesTmpRam_Ready,
    input  logic              i_start,
    input  logic              i_mode,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_QueryRam_rdaddr,
    input  logic [DATA_W-1:0] i_QueryRam_out,
    output logic [ADDR_W-1:0] o_KeyRam_rdaddr,
    input  logic [DATA_W-1:0] i_KeyRam_out,
    output logic [ADDR_W-1:0] o_ValueRam_rdaddr,
    input  logic [DATA_W-1:0] i_ValueRam_out,
    output logic [DATA_W-1:0] o_line_q,
    output logic [DATA_W-1:0] o_line_kv,
    output logic              o_line_valid,
    input  logic              i_line_ready,
    output logic              o_row_last,
    output logic              o_line_last
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [RW-1:0]     ROW_MAX = RW'(ROWS - 1);
    localparam logic [BW-1:0]     BLK_MAX = BW'(BLOCKS - 1);
    localparam logic [ADDR_W-1:0] ROWS_A  = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] LIN_MAX = ADDR_W'(ROWS * BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, RUN, DRAIN} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] kv;
        logic              row_last;
        logic              last;
    } beat_t;

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic [RW-1:0]     qi_q, qi_d, ki_q, ki_d;
    logic [BW-1:0]     blk_q, blk_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] qaddr_q, qaddr_d, kaddr_q, kaddr_d, vaddr_q, vaddr_d;
    logic   infl_q, infl_d, infl_rl_q, infl_rl_d, infl_last_q, infl_last_d;
    beat_t  fifo_q [2];
    beat_t  fifo_d [2];
    logic   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic   done_q, done_d;

    logic   start_acc, pop, issue, is_row_last, is_last;
    logic [2:0] occupancy;
    beat_t  head, cap;

    assign head = fifo_q[rd_ptr_q];

    // The beat leaving this cycle frees its slot, which is what keeps one beat per cycle.
    always_comb begin
        start_acc   = (state_q == IDLE) && i_start && !done_q;
        pop         = (count_q != 2'd0) && i_line_ready;
        occupancy   = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
        issue       = (state_q == RUN) && (occupancy < 3'd2);
        is_row_last = (ki_q == ROW_MAX);
        is_last     = mode_q ? (vaddr_q == LIN_MAX)
                             : (is_row_last && (qi_q == ROW_MAX) && (blk_q == BLK_MAX));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_acc) state_d = i_SpikesTmpRam_Ready ? RUN : WAIT_RDY;
            WAIT_RDY: if (i_SpikesTmpRam_Ready) state_d = RUN;
            RUN:      if (issue && is_last) state_d = DRAIN;
            DRAIN:    if (pop && head.last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // The final address is left on the bus rather than wrapped.
    always_comb begin
        mode_d  = mode_q;
        qi_d    = qi_q;
        ki_d    = ki_q;
        blk_d   = blk_q;
        base_d  = base_q;
        qaddr_d = qaddr_q;
        kaddr_d = kaddr_q;
        vaddr_d = vaddr_q;
        if (start_acc) begin
            mode_d  = i_mode;
            qi_d    = '0;
            ki_d    = '0;
            blk_d   = '0;
            base_d  = '0;
            qaddr_d = '0;
            kaddr_d = '0;
            vaddr_d = '0;
        end else if (issue && !is_last) begin
            if (mode_q) begin
                vaddr_d = vaddr_q + 1'b1;
                ki_d    = is_row_last ? '0 : ki_q + 1'b1;
            end else if (!is_row_last) begin
                ki_d    = ki_q + 1'b1;
                kaddr_d = kaddr_q + 1'b1;
            end else if (qi_q != ROW_MAX) begin
                ki_d    = '0;
                qi_d    = qi_q + 1'b1;
                qaddr_d = qaddr_q + 1'b1;
                kaddr_d = base_q;
            end else begin
                ki_d    = '0;
                qi_d    = '0;
                blk_d   = blk_q + 1'b1;
                base_d  = base_q + ROWS_A;
                qaddr_d = base_q + ROWS_A;
                kaddr_d = base_q + ROWS_A;
            end
        end
    end

    always_comb begin
        infl_d      = issue;
        infl_rl_d   = is_row_last;
        infl_last_d = is_last;
        cap.q        = mode_q ? '0 : i_QueryRam_out;
        cap.kv       = mode_q ? i_ValueRam_out : i_KeyRam_out;
        cap.row_last = infl_rl_q;
        cap.last     = infl_last_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (infl_q) begin
            fifo_d[wr_ptr_q] = cap;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, infl_q} - {1'b0, pop};
        done_d  = (state_q == DRAIN) && pop && head.last;
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            mode_q      <= 1'b0;
            qi_q        <= '0;
            ki_q        <= '0;
            blk_q       <= '0;
            base_q      <= '0;
            qaddr_q     <= '0;
            kaddr_q     <= '0;
            vaddr_q     <= '0;
            infl_q      <= 1'b0;
            infl_rl_q   <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            qi_q        <= qi_d;
            ki_q        <= ki_d;
            blk_q       <= blk_d;
            base_q      <= base_d;
            qaddr_q     <= qaddr_d;
            kaddr_q     <= kaddr_d;
            vaddr_q     <= vaddr_d;
            infl_q      <= infl_d;
            infl_rl_q   <= infl_rl_d;
            infl_last_q <= infl_last_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    assign o_busy            = (state_q != IDLE);
    assign o_done            = done_q;
    assign o_QueryRam_rdaddr = qaddr_q;
    assign o_KeyRam_rdaddr   = kaddr_q;
    assign o_ValueRam_rdaddr = vaddr_q;
    assign o_line_valid      = (count_q != 2'd0);
    assign o_line_q          = head.q;
    assign o_line_kv         = head.kv;
    assign o_row_last        = head.row_last;
    assign o_line_last       = head.last;

endmodule
